// File: rtl/iob_cache_write_through_buffer.sv
// Write-through buffer: queues cache write requests in a circular buffer and
// drains them in order to the back-end memory as IOB-style valid/ready writes.
module iob_cache_write_through_buffer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 2
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_n_i,
  input  logic                  push_i,
  input  logic [ADDR_W-1:0]     push_addr_i,
  input  logic [DATA_W-1:0]     push_wdata_i,
  input  logic [DATA_W/8-1:0]   push_wstrb_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_W:0]      level_o,
  output logic                  overflow_o,
  output logic                  mem_valid_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_wstrb_o,
  input  logic                  mem_ready_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 2 ** DEPTH_W;
  localparam logic [DEPTH_W:0] LVL_FULL = (DEPTH_W + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t              r_state;
  logic [DEPTH_W-1:0]  r_wr_ptr;
  logic [DEPTH_W-1:0]  r_rd_ptr;
  logic [DEPTH_W:0]    r_level;
  logic                r_overflow;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [STRB_W-1:0]   r_mem_wstrb;

  logic [ADDR_W-1:0]   r_addr_q  [DEPTH];
  logic [DATA_W-1:0]   r_wdata_q [DEPTH];
  logic [STRB_W-1:0]   r_wstrb_q [DEPTH];

  logic                w_full;
  logic                w_push_acc;
  logic                w_pop;
  logic                w_head_live;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_wdata;
  logic [STRB_W-1:0]   w_head_wstrb;

  assign w_full       = (r_level == LVL_FULL);
  // A full buffer rejects the push even when a pop frees a slot this cycle.
  assign w_push_acc   = push_i && !w_full;
  assign w_pop        = (r_level != '0) &&
                        ((r_state == S_IDLE) || mem_ready_i);
  assign w_head_addr  = r_addr_q[r_rd_ptr];
  assign w_head_wdata = r_wdata_q[r_rd_ptr];
  assign w_head_wstrb = r_wstrb_q[r_rd_ptr];
  assign w_head_live  = |w_head_wstrb;

  // Entry storage carries no reset; only the pointers and level qualify it.
  always_ff @(posedge clk_i) begin
    if (cke_i && w_push_acc) begin
      r_addr_q[r_wr_ptr]  <= push_addr_i;
      r_wdata_q[r_wr_ptr] <= push_wdata_i;
      r_wstrb_q[r_wr_ptr] <= push_wstrb_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else if (cke_i) begin
      r_overflow <= push_i && w_full;
      r_level    <= r_level + (DEPTH_W + 1)'(w_push_acc) - (DEPTH_W + 1)'(w_pop);
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + DEPTH_W'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + DEPTH_W'(1);

      // Zero-strobe heads are popped and dropped without a memory request.
      case (r_state)
        S_IDLE: begin
          if (w_pop && w_head_live) begin
            r_mem_addr  <= w_head_addr;
            r_mem_wdata <= w_head_wdata;
            r_mem_wstrb <= w_head_wstrb;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready_i) begin
            if (w_pop && w_head_live) begin
              r_mem_addr  <= w_head_addr;
              r_mem_wdata <= w_head_wdata;
              r_mem_wstrb <= w_head_wstrb;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign full_o      = w_full;
  assign empty_o     = (r_level == '0) && (r_state == S_IDLE);
  assign level_o     = r_level;
  assign overflow_o  = r_overflow;
  assign mem_valid_o = (r_state == S_REQ);
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_wstrb_o = r_mem_wstrb;

endmodule
